// File: rtl/pin_array_pkg.sv
// Shared types and defaults for the pin array capture stage.
// A sample is {vout, mid}, with vout in the MSB.
package pin_array_pkg;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STABLE_CNT  = 3;
  localparam int DEF_FIFO_DEPTH  = 4;

  typedef logic [DEF_WIDTH:0] sample_t;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_e;

endpackage

// File: rtl/pin_array_sample_fifo.sv
// Small synchronous sample FIFO. The head is read straight from storage.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module pin_array_sample_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pin_array_sampler.sv
// Capture stage behind the pin array: synchronize {vout, mid}, filter glitches,
// and queue each newly committed stable value for the back end.
module pin_array_sampler
  import pin_array_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             VDD,
  input  logic             VSS,
  input  logic [WIDTH-1:0] mid,
  input  logic             vout,
  input  logic             en,
  output logic [WIDTH:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  input  logic             clr_ovf,
  output state_e           dbg_state
);

  // Handshake: out_data is the head while out_valid is high; the head is
  // consumed on any clock edge where out_valid and out_ready are both high.

  localparam int CW = $clog2(STABLE_CNT + 1);

  logic [WIDTH:0]  sync_q [SYNC_STAGES];
  logic [WIDTH:0]  s;
  logic [WIDTH:0]  prev;
  logic [WIDTH:0]  committed;
  logic [CW-1:0]   cnt;
  state_e          state_q;
  state_e          state_d;
  logic            qualified;
  logic            push;
  logic            drop;
  logic            fifo_full;
  logic            unused_ok;

  // Supply pins are carried for netlist continuity only.
  assign unused_ok = ^{VDD, VSS, fifo_full};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {vout, mid};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Counter saturates, so a held value qualifies exactly once per run.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      prev <= '0;
      cnt  <= '0;
    end else begin
      prev <= s;
      if (state_q == IDLE || s != prev) cnt <= '0;
      else if (cnt < CW'(STABLE_CNT))   cnt <= cnt + 1'b1;
    end
  end

  assign qualified = (s == prev) && (cnt == CW'(STABLE_CNT - 1));
  assign push      = (state_q == TRACK) && qualified && (s != committed);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = TRACK;
      TRACK:   if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Committing on entry to TRACK keeps an already-present value out of the FIFO.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                       committed <= '0;
    else if (state_q == IDLE && en)  committed <= s;
    else if (push)                   committed <= s;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  pin_array_sample_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (push),
    .din   (s),
    .pop   (out_ready),
    .dout  (out_data),
    .valid (out_valid),
    .full  (fifo_full),
    .drop  (drop)
  );

  assign dbg_state = state_q;

endmodule

// File: tb/tb_pin_array_sampler.sv
// Bench for pin_array_sampler: directed scenarios plus randomized holds,
// checked against a run-length model of the stability rule and an expected queue.
module tb_pin_array_sampler;
  import pin_array_pkg::*;

  localparam int W      = 4;
  localparam int STABLE = 3;
  localparam int DEPTH  = 4;

  logic         clk = 1'b0;
  logic         rstb;
  logic         VDD = 1'b1;
  logic         VSS = 1'b0;
  logic [W-1:0] mid;
  logic         vout;
  logic         en;
  logic [W:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         overflow;
  logic         clr_ovf;
  state_e       dbg_state;

  logic [W:0]   exp_q[$];
  logic [W:0]   last_acc;
  logic [W:0]   cur_v;
  logic [W:0]   rv;
  bit           model_track;
  bit           model_ovf;
  int           n_cmp = 0;
  int           n_mis = 0;

  pin_array_sampler dut (
    .clk       (clk),
    .rstb      (rstb),
    .VDD       (VDD),
    .VSS       (VSS),
    .mid       (mid),
    .vout      (vout),
    .en        (en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every accepted pop must match the oldest expected sample
  always @(negedge clk) begin
    #1;
    if (rstb === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      check("pop_expected", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  // Drive value v for 'cycles' clocks. A value held for at least STABLE+1
  // samples that differs from the last accepted one becomes a new sample.
  // rdy_mode: 0 ready low, 1 ready high, 2 random with regular ready,
  // >=3 ready high only on iteration rdy_mode-3.
  task automatic hold_value(input logic [W:0] v, input int cycles, input int rdy_mode);
    if (model_track && cycles >= STABLE + 1 && v != last_acc) begin
      if (rdy_mode == 0 && exp_q.size() >= DEPTH) model_ovf = 1'b1;
      else exp_q.push_back(v);
      last_acc = v;
    end
    cur_v = v;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      {vout, mid} = v;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        2:       out_ready = (k % 2 == 1) || ($urandom_range(0, 1) == 1);
        default: out_ready = (k == rdy_mode - 3);
      endcase
    end
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #2;
    check("drain_done", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rstb = 1'b0; mid = '0; vout = 1'b0; en = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    last_acc = '0; cur_v = '0; model_track = 1'b0; model_ovf = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    repeat (3) @(negedge clk);
    rstb = 1'b1;

    // basic latency
    @(negedge clk);
    out_ready = 1'b1; en = 1'b1; model_track = 1'b1; last_acc = '0;
    repeat (6) @(negedge clk);
    check("state_track", 32'(dbg_state), 32'(TRACK));
    check("en_no_push", 32'(out_valid), 32'd0);
    @(negedge clk);
    {vout, mid} = 5'b10101;
    cur_v = 5'b10101; last_acc = 5'b10101;
    exp_q.push_back(5'b10101);
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      if (e < 6) check("lat_quiet", 32'(out_valid), 32'd0);
      else if (e == 6) begin
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'h15);
      end else check("lat_single", 32'(out_valid), 32'd0);
    end
    drain(10);

    // glitch rejection
    hold_value(5'h00, 8, 1);
    hold_value(5'h03, 2, 1);
    hold_value(5'h00, 8, 1);
    hold_value(5'h03, 10, 1);
    drain(20);

    // enable gating
    @(negedge clk);
    en = 1'b0; model_track = 1'b0;
    hold_value(5'h0F, 8, 1);
    #2;
    check("gate_idle", 32'(dbg_state), 32'(IDLE));
    check("gate_no_push", 32'(out_valid), 32'd0);
    @(negedge clk);
    en = 1'b1; model_track = 1'b1; last_acc = cur_v;
    repeat (6) @(negedge clk);
    #2;
    check("gate_existing", 32'(out_valid), 32'd0);
    hold_value(5'h0E, 8, 1);
    drain(20);

    // overflow
    for (int i = 1; i <= 5; i++) hold_value(5'(i), 6, 0);
    repeat (3) @(negedge clk);
    #2;
    check("ovf_set", 32'(overflow), 32'(model_ovf));
    check("ovf_valid", 32'(out_valid), 32'd1);
    drain(20);
    check("ovf_sticky", 32'(overflow), 32'd1);
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    model_ovf = 1'b0;
    #2;
    check("ovf_clear", 32'(overflow), 32'(model_ovf));

    // full FIFO with pop in the push cycle
    for (int i = 6; i <= 9; i++) hold_value(5'(i), 6, 0);
    hold_value(5'h0A, 8, 3 + 5);
    repeat (2) @(negedge clk);
    #2;
    check("full_pp_ovf", 32'(overflow), 32'd0);
    check("full_pp_valid", 32'(out_valid), 32'd1);
    drain(20);

    // randomized holds
    for (int i = 0; i < 60; i++) begin
      rv = 5'($urandom_range(0, 31));
      while (rv == cur_v) rv = 5'($urandom_range(0, 31));
      hold_value(rv, $urandom_range(1, 8), 2);
    end
    drain(40);
    check("rand_no_ovf", 32'(overflow), 32'd0);

    // reset mid-transfer
    for (int i = 0; i < 5; i++) hold_value(5'h11 + 5'(i), 6, 0);
    repeat (3) @(negedge clk);
    #2;
    check("pre_rst_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("pre_rst_ovf", 32'(overflow), 32'(model_ovf));
    #1;
    rstb = 1'b0; en = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    exp_q.delete(); model_ovf = 1'b0; model_track = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1; out_ready = 1'b1;
    repeat (8) @(negedge clk);
    #2;
    check("post_rst_quiet", 32'(out_valid), 32'd0);
    @(negedge clk);
    en = 1'b1; model_track = 1'b1; last_acc = cur_v;
    repeat (8) @(negedge clk);
    #2;
    check("post_en_quiet", 32'(out_valid), 32'd0);
    hold_value(5'h0A, 8, 1);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
